row_update_scheduler: RTL

//  Sequences one full-generation update of the frame buffer through the row calculator.
//  Per row: reads a row from frame memory, shifts it into the calculator window,

---
 rtl/row_update_scheduler.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/row_update_scheduler.sv
// row_update_scheduler
// Sequences one full-generation update of the frame buffer through the row
// calculator: prime the window with a dead row, then for every row read it,
// shift it in, let the calculator settle and write back the row above it.
// Memory requests are only raised while the display is blanked.
module row_update_scheduler #(
  parameter int ROWS          = 480,
  parameter int ROW_BITS      = 9,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                clkDiv,
  input  logic                rst,
  input  logic                drawRequest,
  input  logic                displayActive,
  input  logic                memAck,
  output logic                memReq,
  output logic                memWe,
  output logic [ROW_BITS-1:0] memRow,
  output logic                reading,
  output logic                clearRow,
  output logic                busy,
  output logic                done,
  output logic                overrun
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRIME  = 3'd1,
    RD     = 3'd2,
    LATCH  = 3'd3,
    SETTLE = 3'd4,
    WR     = 3'd5,
    TAIL   = 3'd6,
    FINISH = 3'd7
  } state_t;

  localparam logic [ROW_BITS:0] CNT_ZERO   = {(ROW_BITS+1){1'b0}};
  localparam logic [ROW_BITS:0] CNT_ONE    = {{ROW_BITS{1'b0}}, 1'b1};
  localparam logic [ROW_BITS:0] CNT_LAST   = (ROW_BITS+1)'(ROWS);
  localparam logic [ROW_BITS:0] CNT_PENULT = (ROW_BITS+1)'(ROWS - 1);
  localparam logic [3:0]        SETTLE_END = 4'(SETTLE_CYCLES - 1);

  state_t            state;
  state_t            state_nx;
  logic              prev_draw;
  logic              start;
  logic [ROW_BITS:0] row_cnt;
  logic [ROW_BITS:0] row_cnt_nx;
  logic [ROW_BITS:0] wr_cnt;
  logic [3:0]        settle_cnt;
  logic [3:0]        settle_cnt_nx;
  logic              req_held;
  logic              req_held_nx;
  logic              req_live;
  logic              xfer;

  // A start is a rising edge of the draw request level.
  assign start  = drawRequest & ~prev_draw;
  // Write-back targets the row above the one most recently shifted in.
  assign wr_cnt = row_cnt - CNT_ONE;
  // A request appears only during blanking, then sticks until acknowledged.
  assign req_live = ((state == RD) || (state == WR)) & (req_held | ~displayActive);
  assign xfer     = req_live & memAck;

  // State register and datapath counters with synchronous active-low reset.
  always_ff @(posedge clkDiv) begin
    if (!rst) begin
      state      <= IDLE;
      prev_draw  <= 1'b1;
      row_cnt    <= CNT_ZERO;
      settle_cnt <= 4'd0;
      req_held   <= 1'b0;
    end else begin
      state      <= state_nx;
      prev_draw  <= drawRequest;
      row_cnt    <= row_cnt_nx;
      settle_cnt <= settle_cnt_nx;
      req_held   <= req_held_nx;
    end
  end

  // Next-state logic and counter updates.
  always_comb begin
    state_nx      = state;
    row_cnt_nx    = row_cnt;
    settle_cnt_nx = settle_cnt;
    req_held_nx   = req_live & ~memAck;
    case (state)
      IDLE: begin
        if (start) begin
          row_cnt_nx = CNT_ZERO;
          state_nx   = PRIME;
        end else begin
          state_nx = IDLE;
        end
      end
      PRIME: state_nx = RD;
      RD: begin
        if (xfer) begin
          state_nx = LATCH;
        end else begin
          state_nx = RD;
        end
      end
      LATCH: begin
        settle_cnt_nx = 4'd0;
        if (row_cnt == CNT_ZERO) begin
          row_cnt_nx = row_cnt + CNT_ONE;
          state_nx   = RD;
        end else begin
          state_nx = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_END) begin
          state_nx = WR;
        end else begin
          settle_cnt_nx = settle_cnt + 4'd1;
          state_nx      = SETTLE;
        end
      end
      WR: begin
        if (!xfer) begin
          state_nx = WR;
        end else if (row_cnt == CNT_LAST) begin
          state_nx = FINISH;
        end else if (row_cnt == CNT_PENULT) begin
          row_cnt_nx = CNT_LAST;
          state_nx   = TAIL;
        end else begin
          row_cnt_nx = row_cnt + CNT_ONE;
          state_nx   = RD;
        end
      end
      TAIL: begin
        settle_cnt_nx = 4'd0;
        state_nx      = SETTLE;
      end
      FINISH: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    memReq   = 1'b0;
    memWe    = 1'b0;
    memRow   = {ROW_BITS{1'b0}};
    reading  = 1'b0;
    clearRow = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: busy = 1'b0;
      PRIME, TAIL: begin
        clearRow = 1'b1;
        busy     = 1'b1;
      end
      RD: begin
        busy   = 1'b1;
        memReq = req_live;
        if (req_live) begin
          memRow = row_cnt[ROW_BITS-1:0];
        end else begin
          memRow = {ROW_BITS{1'b0}};
        end
      end
      LATCH: begin
        reading = 1'b1;
        busy    = 1'b1;
      end
      SETTLE: busy = 1'b1;
      WR: begin
        busy   = 1'b1;
        memReq = req_live;
        memWe  = req_live;
        if (req_live) begin
          memRow = wr_cnt[ROW_BITS-1:0];
        end else begin
          memRow = {ROW_BITS{1'b0}};
        end
      end
      FINISH: done = 1'b1;
      default: busy = 1'b0;
    endcase
    overrun = start & (state != IDLE);
  end

endmodule
